// File: rtl/uart_rx_buffered_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_rx_buffered_pkg;

    // Receive FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    // Number of system clocks per serial bit.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned bit_rate);
        return clk_freq / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_byte_fifo.sv
// Byte FIFO with flush, simultaneous push/pop when full, and a drop indication.
module uart_rx_buffered_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               din,
    input  logic                     rd_en,
    input  logic                     flush,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_rd;
    logic w_wr;

    // Flush wins over everything; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        full  = (r_count == CountFull);
        empty = (r_count == '0);
        w_rd  = rd_en && !empty && !flush;
        w_wr  = wr_en && (!full || w_rd) && !flush;
        drop  = wr_en && full && !rd_en && !flush;
        dout  = r_mem[r_rd_ptr];
        count = r_count;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BIT_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       read,
    input  logic       clean_buffer,
    output logic       data_available,
    output logic [7:0] data_out,
    output logic       full,
    output logic       overrun,
    output logic       framing_error
);
    localparam int unsigned CPB = calc_clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int unsigned CW  = $clog2(CPB);
    localparam logic [CW-1:0] CntLast = CW'(CPB - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CPB / 2 - 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic [1:0]      r_sync_vld;
    logic            r_armed;
    rx_state_e       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_framing_error;
    logic            r_overrun;

    rx_state_e       w_state_next;
    logic [CW-1:0]   w_cnt_next;
    logic [2:0]      w_bit_idx_next;
    logic [7:0]      w_shift_next;
    logic            w_armed_next;
    logic            w_push;
    logic            w_ferr;

    logic [7:0]      w_fifo_dout;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [FCW-1:0]  w_fifo_count;
    logic            w_fifo_drop;

    // Two-flop synchroniser; r_sync_vld marks when r_rx_sync reflects the real line after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_sync_vld <= 2'b00;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // Receive FSM next state: a start is only accepted after the line was seen idle (armed).
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_armed_next   = r_armed;
        w_push         = 1'b0;
        w_ferr         = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (r_rx_sync && r_sync_vld[1]) begin
                    w_armed_next = 1'b1;
                end else if (!r_rx_sync && r_armed) begin
                    w_state_next = StStart;
                    w_armed_next = 1'b0;
                end
            end
            StStart: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_next = '0;
                    if (r_rx_sync) begin
                        w_state_next = StIdle;
                    end else begin
                        w_state_next   = StData;
                        w_bit_idx_next = 3'd0;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            StData: begin
                if (r_cnt == CntLast) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = StStop;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            StStop: begin
                if (r_cnt == CntLast) begin
                    w_cnt_next   = '0;
                    w_state_next = StIdle;
                    if (r_rx_sync) w_push = 1'b1;
                    else           w_ferr = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Receive FSM state, baud counter, shift register and registered error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_bit_idx       <= 3'd0;
            r_shift         <= 8'h00;
            r_armed         <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_bit_idx       <= w_bit_idx_next;
            r_shift         <= w_shift_next;
            r_armed         <= w_armed_next;
            r_framing_error <= w_ferr;
            r_overrun       <= w_fifo_drop;
        end
    end

    uart_rx_buffered_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (w_push),
        .din   (r_shift),
        .rd_en (read),
        .flush (clean_buffer),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count),
        .drop  (w_fifo_drop)
    );

    // Output mapping; head byte reads as zero whenever nothing is queued.
    always_comb begin
        data_available = (w_fifo_count != '0);
        data_out       = w_fifo_empty ? 8'h00 : w_fifo_dout;
        full           = w_fifo_full;
        overrun        = r_overrun;
        framing_error  = r_framing_error;
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered at 16 clocks per bit, 16-entry FIFO.
module tb_uart_rx_buffered;
    localparam int unsigned CLK_FREQ = 25000000;
    localparam int unsigned BIT_RATE = 1562500;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned CPB      = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       read;
    logic       clean_buffer;
    logic       data_available;
    logic [7:0] data_out;
    logic       full;
    logic       overrun;
    logic       framing_error;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BIT_RATE   (BIT_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .read           (read),
        .clean_buffer   (clean_buffer),
        .data_available (data_available),
        .data_out       (data_out),
        .full           (full),
        .overrun        (overrun),
        .framing_error  (framing_error)
    );

    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         mon_checks = 0;
    int         mon_errors = 0;
    int         fe_seen = 0;
    int         ovr_seen = 0;
    logic       fe_prev = 1'b0;
    logic       ovr_prev = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] b55 = 8'h55;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; optionally holds clean_buffer across the stop-bit sample.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flush_at_stop);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(posedge clk);
            #1;
            if (c < CPB)          rx = 1'b0;
            else if (c < 9 * CPB) rx = b[(c / CPB) - 1];
            else                  rx = stop_bit;
            clean_buffer = flush_at_stop && (c >= 10 * CPB - 7) && (c <= 10 * CPB - 5);
        end
        @(posedge clk);
        #1;
        rx = 1'b1;
        clean_buffer = 1'b0;
    endtask

    task automatic do_read();
        @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
    endtask

    // Monitor: compares popped head bytes against the scoreboard and polices pulse widths.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                fe_prev  = 1'b0;
                ovr_prev = 1'b0;
            end else begin
                if (read && data_available) begin
                    mon_checks++;
                    if (exp_q.size() == 0) begin
                        mon_errors++;
                        $display("FAIL pop_unexpected: got %02h expected no data", data_out);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (data_out !== mon_exp) begin
                            mon_errors++;
                            $display("FAIL pop_data: got %02h expected %02h", data_out, mon_exp);
                        end
                    end
                end
                if (fe_prev) begin
                    mon_checks++;
                    if (framing_error !== 1'b0) begin
                        mon_errors++;
                        $display("FAIL framing_error_width: got %b expected 0", framing_error);
                    end
                end
                if (ovr_prev) begin
                    mon_checks++;
                    if (overrun !== 1'b0) begin
                        mon_errors++;
                        $display("FAIL overrun_width: got %b expected 0", overrun);
                    end
                end
                if (framing_error && !fe_prev) fe_seen++;
                if (overrun && !ovr_prev) ovr_seen++;
                fe_prev  = framing_error;
                ovr_prev = overrun;
            end
        end
    end

    initial begin
        rx = 1'b1;
        read = 1'b0;
        clean_buffer = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {data_available, data_out, full, overrun, framing_error}, 32'h0);
        reset = 1'b0;
        idle(5);

        // 1) single frame, then pop
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_avail", data_available, 1);
        check("t1_data", data_out, 8'hA5);
        do_read();
        @(negedge clk);
        check("t1_avail_after_read", data_available, 0);

        // 2) short low glitch
        @(posedge clk);
        #1 rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("t2_avail", data_available, 0);
        check("t2_no_ferr", fe_seen, 0);

        // 3) bad stop bit
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        check("t3_ferr_count", fe_seen, 1);
        check("t3_avail", data_available, 0);

        // 4) fill to full, overrun on the 17th, drain in order
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 15) begin
                @(negedge clk);
                check("t4_full_at_16", full, 1);
                check("t4_no_ovr_yet", ovr_seen, 0);
            end
        end
        idle(2);
        check("t4_ovr_count", ovr_seen, 1);
        check("t4_full_after_17", full, 1);
        check("t4_head", data_out, 8'h00);
        for (int i = 0; i < 16; i++) do_read();
        @(negedge clk);
        check("t4_drained", data_available, 0);
        check("t4_not_full", full, 0);

        // 5) flush with data queued, then a frame completing during flush
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        @(negedge clk);
        check("t5_avail_before_flush", data_available, 1);
        @(posedge clk);
        #1 clean_buffer = 1'b1;
        @(posedge clk);
        #1 clean_buffer = 1'b0;
        @(negedge clk);
        check("t5_avail_after_flush", data_available, 0);
        send_frame(8'h44, 1'b1, 1'b1);
        idle(5);
        check("t5_flush_at_stop", data_available, 0);
        check("t5_no_ovr", ovr_seen, 1);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0);
        @(negedge clk);
        check("t5_resume_avail", data_available, 1);
        do_read();

        // 6) reset mid-frame
        send_frame(8'h42, 1'b1, 1'b0);
        @(negedge clk);
        check("t6_avail_pre_reset", data_available, 1);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            rx = (c < CPB) ? 1'b0 : b55[(c / CPB) - 1];
        end
        rx = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_reset_outputs", {data_available, data_out, full, overrun, framing_error}, 32'h0);
        idle(3);
        reset = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(20);
        check("t6_no_spurious", data_available, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        @(negedge clk);
        check("t6_avail", data_available, 1);
        check("t6_data", data_out, 8'h81);
        do_read();
        @(negedge clk);
        check("t6_avail_after_read", data_available, 0);

        idle(5);
        check("sb_drained", exp_q.size(), 0);
        check("total_ferr", fe_seen, 1);
        check("total_ovr", ovr_seen, 1);
        checks += mon_checks;
        errors += mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
